// File: rtl/cpu_pkg.sv
// Types and defaults shared by the fetch stage and its neighbours in the pipeline.
package cpu_pkg;
  localparam int CPU_ADDR_W = 32;
  localparam int CPU_INSTR_W = 32;
  localparam logic [CPU_ADDR_W-1:0] CPU_RESET_PC = '0;
  localparam logic [CPU_ADDR_W-1:0] FETCH_STRIDE = 4;

  typedef struct packed {
    logic [CPU_ADDR_W-1:0]  pc;
    logic [CPU_INSTR_W-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory request/response plus the decode-side handshake.
interface fetch_unit_if #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
);
  // imem: a request transfers when imem_req && imem_gnt; imem_addr holds until then.
  // imem_rvalid returns one word per granted request, in order, at least a cycle later.
  // decode: an entry transfers when instr_valid && instr_ready on a rising clock edge.
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_gnt;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;
  logic               redirect;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] Instr;
  logic [ADDR_W-1:0]  pc_out;

  modport master (
    output imem_req, imem_addr, instr_valid, Instr, pc_out,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, Instr, pc_out,
    output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, instr_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// Small circular buffer of fetched {pc, instr} entries; flush empties it and beats push.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int  DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  fetch_entry_t     din,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output fetch_entry_t     head
);
  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the fetch PC, keeps one imem request in flight and queues words for decode.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = CPU_ADDR_W,
  parameter int INSTR_W = CPU_INSTR_W,
  parameter int DEPTH   = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = CPU_RESET_PC
) (
  input logic         clk,
  input logic         reset,
  fetch_unit_if.master bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0]  fetch_pc;
  logic [ADDR_W-1:0]  inflight_pc;
  logic [INSTR_W-1:0] rdata;
  logic               outstanding;
  logic               drop;
  logic               grant;
  logic               resp;
  logic               push;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CNT_W-1:0]   count;
  logic [CNT_W:0]     occupancy;
  fetch_entry_t       din;
  fetch_entry_t       head;

  // The word in flight already owns a FIFO slot, so a response always has room.
  assign occupancy    = {1'b0, count} + (CNT_W + 1)'(outstanding);
  assign bus.imem_req = reset && !outstanding && !fifo_full
                        && (occupancy < (CNT_W + 1)'(DEPTH));
  assign bus.imem_addr = fetch_pc;

  assign grant = bus.imem_req && bus.imem_gnt;
  assign resp  = bus.imem_rvalid && outstanding;
  assign rdata = bus.imem_rdata;
  assign push  = resp && !drop && !bus.redirect;
  assign pop   = bus.instr_valid && bus.instr_ready;
  assign din   = '{pc: inflight_pc, instr: rdata};

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      inflight_pc <= '0;
      outstanding <= 1'b0;
      drop        <= 1'b0;
    end else begin
      if (grant) begin
        outstanding <= 1'b1;
        inflight_pc <= fetch_pc;
      end else if (resp) begin
        outstanding <= 1'b0;
      end

      if (bus.redirect)  fetch_pc <= bus.redirect_pc;
      else if (grant)    fetch_pc <= fetch_pc + FETCH_STRIDE;

      // A redirect poisons whatever response is still owed, including one granted this cycle.
      if (bus.redirect)  drop <= (outstanding && !resp) || grant;
      else if (resp)     drop <= 1'b0;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (bus.redirect),
    .din   (din),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count),
    .head  (head)
  );

  assign bus.instr_valid = !fifo_empty;
  assign bus.Instr       = fifo_empty ? '0 : head.instr;
  assign bus.pc_out      = fifo_empty ? '0 : head.pc;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: behavioural instruction memory with configurable grant/latency and a decode scoreboard.
module tb_fetch_unit;
  logic clk = 1'b0;
  logic reset = 1'b0;

  fetch_unit_if #(.ADDR_W(32), .INSTR_W(32)) bus ();

  fetch_unit #(.DEPTH(2), .RESET_PC(32'h0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          accepts = 0;
  int          last_acc_cyc = -1;
  int          grants = 0;
  logic [31:0] last_grant_addr = '0;
  bit          gnt_en = 1'b0;
  int          lat = 1;
  logic [63:0] exp_q[$];
  pend_t       pend_q[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, a[31:16] + 16'h1357};
  endfunction

  // One clock: drive memory response, sample at negedge+1, record grants and decode transfers.
  task automatic cycle();
    logic [63:0] exp_e;
    bus.imem_gnt = gnt_en;
    if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = mem_word(pend_q[0].addr);
      void'(pend_q.pop_front());
    end else begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = $urandom;
    end
    #1;
    if (bus.imem_req === 1'b1 && bus.imem_gnt === 1'b1) begin
      grants++;
      last_grant_addr = bus.imem_addr;
      pend_q.push_back('{addr: bus.imem_addr, due: cyc + lat});
    end
    if (bus.instr_valid === 1'b1 && bus.instr_ready === 1'b1) begin
      accepts++;
      last_acc_cyc = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected got pc=%h instr=%h, expected nothing", bus.pc_out, bus.Instr);
      end else begin
        exp_e = exp_q.pop_front();
        if ({bus.pc_out, bus.Instr} !== exp_e)
          begin
            errors++;
            $display("FAIL sb_entry got pc=%h instr=%h expected pc=%h instr=%h",
                     bus.pc_out, bus.Instr, exp_e[63:32], exp_e[31:0]);
          end
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_until_accepts(input int target, input int budget, output bit ok);
    int n;
    n  = 0;
    ok = 1'b1;
    while (accepts < target) begin
      if (n >= budget) begin
        ok = 1'b0;
        break;
      end
      cycle();
      n++;
    end
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    bus.redirect = 1'b0;
    gnt_en = 1'b0;
    pend_q.delete();
    exp_q.delete();
    repeat (2) cycle();
    reset = 1'b1;
    cyc = 0;
    grants = 0;
    accepts = 0;
    last_acc_cyc = -1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) cycle();
    checks++;
    if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b expected 0", bus.imem_req); end
    checks++;
    if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b expected 0", bus.instr_valid); end
    checks++;
    if (bus.Instr !== 32'h0 || bus.pc_out !== 32'h0) begin
      errors++; $display("FAIL reset_outputs got instr=%h pc=%h expected 0/0", bus.Instr, bus.pc_out);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
      errors++; $display("FAIL reset_first_req got req=%b addr=%h expected 1/00000000", bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_stream();
    bit ok;
    apply_reset();
    gnt_en = 1'b1; lat = 1; bus.instr_ready = 1'b1;
    for (int k = 0; k < 4; k++) exp_q.push_back({32'(4 * k), mem_word(32'(4 * k))});
    for (int k = 0; k < 4; k++) begin
      run_until_accepts(k + 1, 10, ok);
      checks++;
      if (!ok || last_acc_cyc != 2 + 2 * k) begin
        errors++; $display("FAIL stream_timing entry %0d got cycle %0d (ok=%0b) expected %0d", k, last_acc_cyc, ok, 2 + 2 * k);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL stream_drain got %0d left expected 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    bit ok;
    apply_reset();
    gnt_en = 1'b1; lat = 1; bus.instr_ready = 1'b0;
    repeat (10) cycle();
    checks++;
    if (bus.instr_valid !== 1'b1 || bus.imem_req !== 1'b0) begin
      errors++; $display("FAIL bp_full got valid=%b req=%b expected 1/0", bus.instr_valid, bus.imem_req);
    end
    checks++;
    if (grants != 2) begin errors++; $display("FAIL bp_grants got %0d expected 2", grants); end
    checks++;
    if (bus.pc_out !== 32'h0) begin errors++; $display("FAIL bp_head got %h expected 00000000", bus.pc_out); end
    for (int k = 0; k < 3; k++) exp_q.push_back({32'(4 * k), mem_word(32'(4 * k))});
    bus.instr_ready = 1'b1;
    run_until_accepts(3, 20, ok);
    checks++;
    if (!ok || exp_q.size() != 0) begin
      errors++; $display("FAIL bp_release got ok=%0b left=%0d expected 1/0", ok, exp_q.size());
    end
  endtask

  task automatic test_redirect_outstanding();
    bit ok;
    int n;
    apply_reset();
    gnt_en = 1'b1; lat = 3; bus.instr_ready = 1'b1;
    exp_q.push_back({32'h0, mem_word(32'h0)});
    exp_q.push_back({32'h4, mem_word(32'h4)});
    exp_q.push_back({32'h100, mem_word(32'h100)});
    exp_q.push_back({32'h104, mem_word(32'h104)});
    n = 0;
    while (grants < 3 && n < 40) begin cycle(); n++; end
    checks++;
    if (grants < 3 || last_grant_addr !== 32'h8) begin
      errors++; $display("FAIL redir_setup got grants=%0d addr=%h expected 3/00000008", grants, last_grant_addr);
    end
    // Two back-to-back redirects while 0x8 is owed: only that single response may be dropped.
    bus.redirect = 1'b1; bus.redirect_pc = 32'h80;
    cycle();
    bus.redirect_pc = 32'h100;
    cycle();
    bus.redirect = 1'b0;
    run_until_accepts(4, 40, ok);
    checks++;
    if (!ok || exp_q.size() != 0) begin
      errors++; $display("FAIL redir_outstanding got ok=%0b left=%0d expected 1/0", ok, exp_q.size());
    end
  endtask

  task automatic test_redirect_rvalid_pop();
    bit ok;
    int n;
    apply_reset();
    gnt_en = 1'b1; lat = 3; bus.instr_ready = 1'b0;
    exp_q.push_back({32'h0, mem_word(32'h0)});
    n = 0;
    while (grants < 2 && n < 40) begin cycle(); n++; end
    while (pend_q.size() > 0 && pend_q[0].due > cyc && n < 40) begin cycle(); n++; end
    checks++;
    if (bus.instr_valid !== 1'b1 || pend_q.size() != 1) begin
      errors++; $display("FAIL rp_setup got valid=%b pending=%0d expected 1/1", bus.instr_valid, pend_q.size());
    end
    bus.instr_ready = 1'b1;
    bus.redirect = 1'b1; bus.redirect_pc = 32'h200;
    cycle();
    bus.redirect = 1'b0;
    #1;
    checks++;
    if (accepts != 1) begin errors++; $display("FAIL rp_pop got accepts=%0d expected 1", accepts); end
    checks++;
    if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h200) begin
      errors++; $display("FAIL rp_after got valid=%b req=%b addr=%h expected 0/1/00000200",
                         bus.instr_valid, bus.imem_req, bus.imem_addr);
    end
    exp_q.push_back({32'h200, mem_word(32'h200)});
    run_until_accepts(2, 20, ok);
    checks++;
    if (!ok || exp_q.size() != 0) begin
      errors++; $display("FAIL rp_refetch got ok=%0b left=%0d expected 1/0", ok, exp_q.size());
    end
  endtask

  task automatic test_gnt_stall_redirect();
    bit ok;
    logic [31:0] exp_addr;
    apply_reset();
    gnt_en = 1'b0; lat = 1; bus.instr_ready = 1'b1;
    bus.redirect = 1'b1; bus.redirect_pc = 32'h10;
    cycle();
    bus.redirect = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k == 2) begin bus.redirect = 1'b1; bus.redirect_pc = 32'h40; end
      exp_addr = (k < 3) ? 32'h10 : 32'h40;
      #1;
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== exp_addr) begin
        errors++; $display("FAIL stall_addr cycle %0d got req=%b addr=%h expected 1/%h", k, bus.imem_req, bus.imem_addr, exp_addr);
      end
      cycle();
      bus.redirect = 1'b0;
    end
    checks++;
    if (grants != 0) begin errors++; $display("FAIL stall_grants got %0d expected 0", grants); end
    gnt_en = 1'b1;
    exp_q.push_back({32'h40, mem_word(32'h40)});
    exp_q.push_back({32'h44, mem_word(32'h44)});
    run_until_accepts(2, 20, ok);
    checks++;
    if (!ok || exp_q.size() != 0) begin
      errors++; $display("FAIL stall_resume got ok=%0b left=%0d expected 1/0", ok, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n;
    int target;
    apply_reset();
    gnt_en = 1'b1; lat = 3; bus.instr_ready = 1'b0;
    n = 0;
    while (grants < 2 && n < 40) begin cycle(); n++; end
    checks++;
    if (bus.instr_valid !== 1'b1 || pend_q.size() != 1) begin
      errors++; $display("FAIL rm_setup got valid=%b pending=%0d expected 1/1", bus.instr_valid, pend_q.size());
    end
    reset = 1'b0;
    cycle();
    checks++;
    if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b0) begin
      errors++; $display("FAIL rm_cleared got valid=%b req=%b expected 0/0", bus.instr_valid, bus.imem_req);
    end
    // Hold off grants so the stale response lands while nothing is outstanding.
    gnt_en = 1'b0;
    reset = 1'b1;
    n = 0;
    while (pend_q.size() > 0 && n < 20) begin cycle(); n++; end
    #1;
    checks++;
    if (pend_q.size() != 0 || bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
      errors++; $display("FAIL rm_stale got pending=%0d valid=%b req=%b addr=%h expected 0/0/1/00000000",
                         pend_q.size(), bus.instr_valid, bus.imem_req, bus.imem_addr);
    end
    gnt_en = 1'b1; bus.instr_ready = 1'b1;
    exp_q.push_back({32'h0, mem_word(32'h0)});
    target = accepts + 1;
    run_until_accepts(target, 20, ok);
    checks++;
    if (!ok || exp_q.size() != 0) begin
      errors++; $display("FAIL rm_restart got ok=%0b left=%0d expected 1/0", ok, exp_q.size());
    end
  endtask

  initial begin
    bus.imem_gnt = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata = '0;
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;
    bus.instr_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_outstanding();
    test_redirect_rvalid_pop();
    test_gnt_stall_redirect();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish by 200000 time units");
    $fatal(1);
  end
endmodule
